step_pause_ctrl: RTL
====================

# step_pause_ctrl

Generates the `pause` input of the multi-cycle CPU state register. It supports free-run and single-step execution, with single-stepping either one state or one instruction per debounced button press. It also inserts fixed memory wait cycles on memory-access states. It sits between the board switches/button, the control decoder and the state register, all on `multi_clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable samples needed to accept a button level change. Must be ≥2.
- `WAIT_STATES`, default 2: pause cycles inserted per memory-access state. 0 disables memory waits.
- `FETCH_STATE`, default 4'd0: state code that marks an instruction boundary.
- `multi_clk  in  1`: CPU state clock. This is the only clock.
- `rst  in  1`: reset. Synchronous, active-high.
- `run_mode  in  1`: asynchronous switch. 1 = free-run, 0 = single-step.
- `step_instr  in  1`: asynchronous switch. 0 = one state per press, 1 = one instruction per press.
- `step_btn  in  1`: raw asynchronous push-button, active-high.
- `mem_req  in  1`: decoded from `current_state`. High while the current state accesses memory.
- `current_state  in  4`: output of the state register.
- `pause  out  1`: hold the state register when high.
- `step_busy  out  1`: a step is in progress (FSM not in S_HOLD).
- `mem_wait  out  1`: pause is currently caused by a memory wait.

## Operation
- **Synchronizers:** `run_mode`, `step_instr` and `step_btn` each pass through a 2-flop synchronizer. All three reset to 0.
- **Debounce:**
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - While the synchronized button equals the debounced level `db`, the counter is held at 0.
  - Otherwise the counter increments. At count DEBOUNCE_CYCLES-1 with the inputs still differing, `db` takes the new level and the counter clears.
  - `step_pulse` = `db` & ~`db_q`, a one-cycle pulse on each debounced rising edge.
- **Memory wait:**
  - `mem_wait` = `mem_req` && (`wcnt` < WAIT_STATES).
  - `wcnt` increments each cycle `mem_wait` is high. It counts regardless of step holds.
  - `wcnt` clears on any cycle with `pause`=0, so back-to-back memory states each get their own wait.
- **Step FSM** (state S_HOLD, S_GO or S_INSTR, plus flag `left`):
  - S_HOLD: on `step_pulse` with sync `run_mode`=0, go to S_GO if sync `step_instr`=0, else go to S_INSTR with `left`=0. Pulses in any other state, or in run mode, are dropped.
  - S_GO: `step_hold`=0. Return to S_HOLD on the first cycle with `pause`=0. Exactly one state advance per press, even if a memory wait intervenes.
  - S_INSTR: `step_hold` = `left` && (`current_state`==FETCH_STATE). Set `left` on the first cycle with `pause`=0. When `step_hold`=1, go to S_HOLD.
  - Sync `run_mode`=1 forces the FSM to S_HOLD and `left`=0 on the next edge.
- **Pause:**
  - `step_hold` in S_HOLD = ~sync `run_mode`.
  - `pause` = `step_hold` | `mem_wait`. It is combinational from registers and `current_state`/`mem_req`, and settles before the next `multi_clk` edge.
- **Reset:**
  - FSM goes to S_HOLD, `left`=0, `wcnt`=0, `db`=`db_q`=0, debounce counter=0, synchronizers=0.
  - Outputs after reset: `pause`=1, `step_busy`=0, `mem_wait`=0 (when `mem_req`=0).
  - In run mode, `pause` stays 1 for 2 cycles until `run_mode` propagates through its synchronizer.
  - Reset mid-step or mid-wait abandons the step. It does not produce a state advance.

## Timing
- Edge 1 is the first edge sampling `step_btn`=1 (button held stable):
  - `db` rises at edge DEBOUNCE_CYCLES+2.
  - FSM enters S_GO at edge DEBOUNCE_CYCLES+3.
  - State register advances at edge DEBOUNCE_CYCLES+4 (edge 20 at default).
- Memory wait: a state with `mem_req`=1 is held for exactly WAIT_STATES cycles and advances on edge WAIT_STATES+1 after entry, when not step-held.
- `run_mode` change takes effect on `pause` 2 edges after sampling.
- Button glitches shorter than DEBOUNCE_CYCLES samples produce no pulse.

## Test plan
- Reset with `run_mode`=1, `mem_req`=0 -> `pause`=1 for 2 cycles, then 0 continuously; `step_busy`=0.
- Step mode, `step_instr`=0, clean press -> `pause` low for exactly 1 cycle, beginning after edge 19; one state advance; further presses during the step are ignored.
- Press with 10-cycle bounce (toggle every 3 cycles) then stable high -> exactly one `step_pulse`, issued DEBOUNCE_CYCLES+1 cycles after the last toggle.
- Run mode, WAIT_STATES=2, two consecutive `mem_req` states -> `mem_wait` high 2 cycles in each state; each state lasts 3 cycles.
- `step_instr`=1, 5-state instruction starting at FETCH_STATE, one memory state -> `pause` low until `current_state` returns to 4'd0, then held; total of 5 advances; `step_busy` falls on return to fetch.
- `rst` pulsed while in S_INSTR with `wcnt`=1 -> next cycle: S_HOLD, `wcnt`=0, `pause`=1, no further advance without a new press.

Source files
------------

// File: rtl/step_pause_ctrl.sv
// -----------------------------------------------------------------------------
// step_pause_ctrl
//
// Produces the pause input of the multi-cycle CPU state register. It supports
// free-run and single-step execution. A single step is either one state or
// one instruction per debounced button press. It also inserts a fixed number
// of wait cycles on every memory-access state.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a button
//                     level change (>= 2)
//   WAIT_STATES     : pause cycles inserted per memory-access state (0 = none)
//   FETCH_STATE     : state code that marks an instruction boundary
//
// Ports
//   multi_clk     in   CPU state clock (only clock)
//   rst           in   synchronous active-high reset
//   run_mode      in   async switch: 1 = free-run, 0 = single-step
//   step_instr    in   async switch: 0 = one state per press, 1 = one instruction
//   step_btn      in   raw async push-button, active-high
//   mem_req       in   current state accesses memory
//   current_state in   output of the CPU state register
//   pause         out  hold the state register when high
//   step_busy     out  a step is in progress
//   mem_wait      out  pause is currently caused by a memory wait
// -----------------------------------------------------------------------------
module step_pause_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         WAIT_STATES     = 2,
    parameter logic [3:0] FETCH_STATE     = 4'd0
) (
    input  logic       multi_clk,
    input  logic       rst,
    input  logic       run_mode,
    input  logic       step_instr,
    input  logic       step_btn,
    input  logic       mem_req,
    input  logic [3:0] current_state,
    output logic       pause,
    output logic       step_busy,
    output logic       mem_wait
);

    localparam int             DBW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam int             WW       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WW-1:0]  WAIT_LIM = WW'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_GO    = 2'd1,
        S_INSTR = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronizers: bit 0 run_mode, bit 1 step_instr, bit 2 step_btn
    // -------------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_vec;

    assign async_in = {step_btn, step_instr, run_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            always_ff @(posedge multi_clk) begin
                if (rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign sync_vec[gi] = s2_reg;
        end
    endgenerate

    logic run_s;
    logic instr_s;
    logic btn_s;

    assign run_s   = sync_vec[0];
    assign instr_s = sync_vec[1];
    assign btn_s   = sync_vec[2];

    // -------------------------------------------------------------------------
    // Debounce: the counter only runs while the synchronized button disagrees
    // with the accepted level; any agreeing sample restarts the count.
    // -------------------------------------------------------------------------
    logic [DBW-1:0] db_cnt_reg;
    logic           db_reg;
    logic           db_q_reg;
    logic           step_pulse;

    always_ff @(posedge multi_clk) begin
        if (rst) begin
            db_cnt_reg <= '0;
            db_reg     <= 1'b0;
            db_q_reg   <= 1'b0;
        end else begin
            db_q_reg <= db_reg;
            if (btn_s == db_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_reg     <= btn_s;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    assign step_pulse = db_reg & ~db_q_reg;

    // -------------------------------------------------------------------------
    // Memory wait. The counter keeps running during a step hold, so a memory
    // state reached by a step has usually used up its wait before the next
    // press. Clearing on every advance gives back-to-back memory states
    // their own wait.
    // -------------------------------------------------------------------------
    logic [WW-1:0] wcnt_reg;

    assign mem_wait = mem_req && (wcnt_reg < WAIT_LIM);

    always_ff @(posedge multi_clk) begin
        if (rst) begin
            wcnt_reg <= '0;
        end else if (!pause) begin
            wcnt_reg <= '0;
        end else if (mem_wait) begin
            wcnt_reg <= wcnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Step FSM. left_reg records that the instruction has moved off its
    // starting state, so the fetch state it started from does not end it.
    // -------------------------------------------------------------------------
    state_t state_reg;
    logic   left_reg;
    logic   busy_reg;
    logic   step_hold;

    always_comb begin
        step_hold = 1'b1;
        case (state_reg)
            S_HOLD:  step_hold = ~run_s;
            S_GO:    step_hold = 1'b0;
            S_INSTR: step_hold = left_reg && (current_state == FETCH_STATE);
            default: step_hold = 1'b1;
        endcase
    end

    assign pause     = step_hold | mem_wait;
    assign step_busy = busy_reg;

    always_ff @(posedge multi_clk) begin
        if (rst) begin
            state_reg <= S_HOLD;
            left_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (run_s) begin
            // Free-run overrides any step in progress.
            state_reg <= S_HOLD;
            left_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_HOLD: begin
                    if (step_pulse) begin
                        busy_reg <= 1'b1;
                        if (!instr_s) begin
                            state_reg <= S_GO;
                        end else begin
                            state_reg <= S_INSTR;
                            left_reg  <= 1'b0;
                        end
                    end
                end
                S_GO: begin
                    // Stays here through any memory wait until one advance.
                    if (!pause) begin
                        state_reg <= S_HOLD;
                        busy_reg  <= 1'b0;
                    end
                end
                S_INSTR: begin
                    if (!pause) begin
                        left_reg <= 1'b1;
                    end
                    if (step_hold) begin
                        state_reg <= S_HOLD;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_HOLD;
                    left_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
